// File: rtl/vliw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vliw_pkg
// Description : Shared constants and types for the 4-slot VLIW issue stage.
//               Slot numbering: 0 LSU, 1 IXU1, 2 IXU2, 3 BRANCH.
// Revision    : 1.0 - initial release
// ============================================================================
package vliw_pkg;

    localparam int SLOT_LSU    = 0;
    localparam int SLOT_IXU1   = 1;
    localparam int SLOT_IXU2   = 2;
    localparam int SLOT_BRANCH = 3;

    localparam int NUM_SLOTS   = 4;
    localparam int NUM_REGS    = 32;

    typedef logic [4:0]           reg_idx_t;
    typedef logic [NUM_SLOTS-1:0] slot_vec_t;
    typedef logic [NUM_REGS-1:0]  reg_vec_t;

endpackage : vliw_pkg
`default_nettype wire

// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard_if
// Description : Issue bundle and writeback bus between decode/execute and the
//               register scoreboard.
//   issue_valid / issue_ready : bundle handshake
//   slot_*                    : per-slot operand and destination fields
//   wb_en / wb_rd             : per-unit register-file writeback
//   master : decode/execute side, slave : scoreboard side
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if;
    import vliw_pkg::*;

    logic                         issue_valid;
    logic                         issue_ready;
    slot_vec_t                    slot_valid;
    reg_idx_t [NUM_SLOTS-1:0]     slot_rs1;
    slot_vec_t                    slot_rs1_use;
    reg_idx_t [NUM_SLOTS-1:0]     slot_rs2;
    slot_vec_t                    slot_rs2_use;
    reg_idx_t [NUM_SLOTS-1:0]     slot_rd;
    slot_vec_t                    slot_rd_use;
    slot_vec_t                    wb_en;
    reg_idx_t [NUM_SLOTS-1:0]     wb_rd;

    modport master (
        output issue_valid, slot_valid, slot_rs1, slot_rs1_use,
               slot_rs2, slot_rs2_use, slot_rd, slot_rd_use, wb_en, wb_rd,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, slot_valid, slot_rs1, slot_rs1_use,
               slot_rs2, slot_rs2_use, slot_rd, slot_rd_use, wb_en, wb_rd,
        output issue_ready
    );

endinterface : reg_scoreboard_if
`default_nettype wire

// File: rtl/reg_scoreboard_hazard_chk.sv
`default_nettype none
// ============================================================================
// Module      : scoreboard_hazard_chk
// Description : Combinational hazard detection for one issue bundle.
//   i_busy        : registered busy vector
//   i_slot_*      : bundle fields
//   o_raw         : an effective source is busy
//   o_waw         : an effective destination is busy
//   o_dup         : two effective destinations share an index
//   o_dst_eff     : per-slot effective-destination mask
// Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_hazard_chk
    import vliw_pkg::*;
(
    input  var reg_vec_t                  i_busy,
    input  var slot_vec_t                 i_slot_valid,
    input  var reg_idx_t [NUM_SLOTS-1:0]  i_slot_rs1,
    input  var slot_vec_t                 i_slot_rs1_use,
    input  var reg_idx_t [NUM_SLOTS-1:0]  i_slot_rs2,
    input  var slot_vec_t                 i_slot_rs2_use,
    input  var reg_idx_t [NUM_SLOTS-1:0]  i_slot_rd,
    input  var slot_vec_t                 i_slot_rd_use,
    output logic                          o_raw,
    output logic                          o_waw,
    output logic                          o_dup,
    output slot_vec_t                     o_dst_eff
);

    slot_vec_t w_src1_eff;
    slot_vec_t w_src2_eff;
    slot_vec_t w_dst_eff;

    // Register 0 is hardwired zero, so it is never an effective operand.
    always_comb begin
        w_src1_eff = '0;
        w_src2_eff = '0;
        w_dst_eff  = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            w_src1_eff[s] = i_slot_valid[s] & i_slot_rs1_use[s] & (i_slot_rs1[s] != '0);
            w_src2_eff[s] = i_slot_valid[s] & i_slot_rs2_use[s] & (i_slot_rs2[s] != '0);
            w_dst_eff[s]  = i_slot_valid[s] & i_slot_rd_use[s]  & (i_slot_rd[s]  != '0);
        end
    end

    always_comb begin
        o_raw = 1'b0;
        o_waw = 1'b0;
        o_dup = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (w_src1_eff[s] && i_busy[i_slot_rs1[s]]) o_raw = 1'b1;
            if (w_src2_eff[s] && i_busy[i_slot_rs2[s]]) o_raw = 1'b1;
            if (w_dst_eff[s]  && i_busy[i_slot_rd[s]])  o_waw = 1'b1;
            for (int t = s + 1; t < NUM_SLOTS; t++) begin
                if (w_dst_eff[s] && w_dst_eff[t] && (i_slot_rd[s] == i_slot_rd[t]))
                    o_dup = 1'b1;
            end
        end
    end

    assign o_dst_eff = w_dst_eff;

endmodule : scoreboard_hazard_chk
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Issue-stage register scoreboard. Tracks a busy bit per
//               architectural register with a write in flight, holds off
//               hazarding bundles and clears bits on unit writeback.
//   clk, rst        : clock, asynchronous active-high reset
//   bus             : issue bundle + writeback interface (slave side)
//   busy            : registered busy vector, bit 0 always 0
//   outstanding     : popcount of busy
//   dup_rd_err      : sticky, bundle had a duplicate nonzero rd
//   spurious_wb_err : sticky, writeback to a non-busy register
//   stall_cycles    : saturating count of stalled issue cycles
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import vliw_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    reg_scoreboard_if.slave        bus,
    output logic [NUM_REGS-1:0]    busy,
    output logic [5:0]             outstanding,
    output logic                   dup_rd_err,
    output logic                   spurious_wb_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    reg_vec_t               r_busy;
    logic [5:0]             r_outstanding;
    logic                   r_dup_rd_err;
    logic                   r_spurious_wb_err;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic      w_raw;
    logic      w_waw;
    logic      w_dup;
    slot_vec_t w_dst_eff;
    logic      w_ready;
    logic      w_fire;
    reg_vec_t  w_set;
    reg_vec_t  w_clr;
    reg_vec_t  w_busy_nxt;
    logic      w_spurious;
    logic [5:0] w_outstanding_nxt;

    scoreboard_hazard_chk u_hazard_chk (
        .i_busy         (r_busy),
        .i_slot_valid   (bus.slot_valid),
        .i_slot_rs1     (bus.slot_rs1),
        .i_slot_rs1_use (bus.slot_rs1_use),
        .i_slot_rs2     (bus.slot_rs2),
        .i_slot_rs2_use (bus.slot_rs2_use),
        .i_slot_rd      (bus.slot_rd),
        .i_slot_rd_use  (bus.slot_rd_use),
        .o_raw          (w_raw),
        .o_waw          (w_waw),
        .o_dup          (w_dup),
        .o_dst_eff      (w_dst_eff)
    );

    assign w_ready         = ~(w_raw | w_waw | w_dup);
    assign w_fire          = bus.issue_valid & w_ready;
    assign bus.issue_ready = w_ready;

    // Clears are evaluated against the registered busy vector, so a
    // writeback to a bit being set in this same cycle is spurious; the set
    // is then applied last and wins.
    always_comb begin
        w_set      = '0;
        w_clr      = '0;
        w_spurious = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (w_fire && w_dst_eff[s])
                w_set[bus.slot_rd[s]] = 1'b1;
            if (bus.wb_en[s] && (bus.wb_rd[s] != '0)) begin
                w_clr[bus.wb_rd[s]] = 1'b1;
                if (!r_busy[bus.wb_rd[s]])
                    w_spurious = 1'b1;
            end
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    assign w_outstanding_nxt = 6'($countones(w_busy_nxt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy            <= '0;
            r_outstanding     <= '0;
            r_dup_rd_err      <= 1'b0;
            r_spurious_wb_err <= 1'b0;
            r_stall_cycles    <= '0;
        end else begin
            r_busy        <= w_busy_nxt;
            r_outstanding <= w_outstanding_nxt;
            if (bus.issue_valid && w_dup)
                r_dup_rd_err <= 1'b1;
            if (w_spurious)
                r_spurious_wb_err <= 1'b1;
            if (bus.issue_valid && !w_ready && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign busy            = r_busy;
    assign outstanding     = r_outstanding;
    assign dup_rd_err      = r_dup_rd_err;
    assign spurious_wb_err = r_spurious_wb_err;
    assign stall_cycles    = r_stall_cycles;

endmodule : reg_scoreboard
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Self-checking bench for reg_scoreboard with directed steps,
//               a randomized phase and a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;
    import vliw_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_scoreboard_if bus();

    logic [31:0] busy;
    logic [5:0]  outstanding;
    logic        dup_rd_err;
    logic        spurious_wb_err;
    logic [15:0] stall_cycles;

    reg_scoreboard #(.STALL_CNT_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .busy            (busy),
        .outstanding     (outstanding),
        .dup_rd_err      (dup_rd_err),
        .spurious_wb_err (spurious_wb_err),
        .stall_cycles    (stall_cycles)
    );

    int total = 0;
    int bad   = 0;

    // stimulus for the current cycle
    int iv;
    int sv[4], r1[4], u1[4], r2[4], u2[4], rd[4], ud[4], we[4], wr[4];

    // reference model state
    bit mb[32];
    bit mdup, mspur;
    int mstall;
    logic last_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        iv = 0;
        for (int s = 0; s < 4; s++) begin
            sv[s] = 0; r1[s] = 0; u1[s] = 0; r2[s] = 0; u2[s] = 0;
            rd[s] = 0; ud[s] = 0; we[s] = 0; wr[s] = 0;
        end
    endtask

    task automatic drive();
        bus.issue_valid = iv[0];
        for (int s = 0; s < 4; s++) begin
            bus.slot_valid[s]   = sv[s][0];
            bus.slot_rs1[s]     = r1[s][4:0];
            bus.slot_rs1_use[s] = u1[s][0];
            bus.slot_rs2[s]     = r2[s][4:0];
            bus.slot_rs2_use[s] = u2[s][0];
            bus.slot_rd[s]      = rd[s][4:0];
            bus.slot_rd_use[s]  = ud[s][0];
            bus.wb_en[s]        = we[s][0];
            bus.wb_rd[s]        = wr[s][4:0];
        end
    endtask

    function automatic bit dst_eff(int s);
        return (sv[s] != 0) && (ud[s] != 0) && (rd[s] != 0);
    endfunction

    // Count writers per register; any count above one is a duplicate.
    function automatic bit model_dup();
        int cnt[32];
        for (int r = 0; r < 32; r++) cnt[r] = 0;
        for (int s = 0; s < 4; s++) if (dst_eff(s)) cnt[rd[s]]++;
        for (int r = 1; r < 32; r++) if (cnt[r] > 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_ready();
        for (int s = 0; s < 4; s++) begin
            if (sv[s] == 0) continue;
            if (u1[s] != 0 && r1[s] != 0 && mb[r1[s]]) return 1'b0;
            if (u2[s] != 0 && r2[s] != 0 && mb[r2[s]]) return 1'b0;
            if (ud[s] != 0 && rd[s] != 0 && mb[rd[s]]) return 1'b0;
        end
        return !model_dup();
    endfunction

    function automatic logic [31:0] mvec();
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = mb[r];
        return v;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int r = 0; r < 32; r++) if (mb[r]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mb[r] = 1'b0;
        mdup = 1'b0; mspur = 1'b0; mstall = 0;
    endtask

    // One clock: check the combinational ready, advance the model, then
    // check all registered outputs after the edge.
    task automatic cycle();
        bit exp_r, fire, dupn;
        bit nb[32];
        drive();
        #2;
        exp_r = model_ready();
        dupn  = model_dup();
        last_ready = bus.issue_ready;
        chk("issue_ready", {63'd0, bus.issue_ready}, {63'd0, exp_r});
        fire = (iv != 0) && exp_r;
        nb = mb;
        for (int s = 0; s < 4; s++) begin
            if (we[s] != 0 && wr[s] != 0) begin
                if (!mb[wr[s]]) mspur = 1'b1;
                nb[wr[s]] = 1'b0;
            end
        end
        for (int s = 0; s < 4; s++) if (fire && dst_eff(s)) nb[rd[s]] = 1'b1;
        mb = nb;
        if (iv != 0 && dupn) mdup = 1'b1;
        if (iv != 0 && !exp_r && mstall < 65535) mstall++;
        @(posedge clk);
        #1;
        chk("busy", {32'd0, busy}, {32'd0, mvec()});
        chk("outstanding", {58'd0, outstanding}, 64'(mcount()));
        chk("dup_rd_err", {63'd0, dup_rd_err}, {63'd0, mdup});
        chk("spurious_wb_err", {63'd0, spurious_wb_err}, {63'd0, mspur});
        chk("stall_cycles", {48'd0, stall_cycles}, 64'(mstall));
    endtask

    initial begin
        rst = 1'b1;
        clear_stim();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_busy", {32'd0, busy}, 64'd0);
        chk("rst_outstanding", {58'd0, outstanding}, 64'd0);
        chk("rst_errs", {62'd0, dup_rd_err, spurious_wb_err}, 64'd0);
        chk("rst_stall", {48'd0, stall_cycles}, 64'd0);

        // first bundle: slot1 writes r5, slot0 reads r3
        clear_stim(); iv = 1;
        sv[SLOT_IXU1] = 1; rd[SLOT_IXU1] = 5; ud[SLOT_IXU1] = 1;
        sv[SLOT_LSU] = 1;  r1[SLOT_LSU] = 3;  u1[SLOT_LSU] = 1;
        cycle();
        chk("first_ready", {63'd0, last_ready}, 64'd1);
        chk("first_busy5", {63'd0, busy[5]}, 64'd1);
        chk("first_outstanding", {58'd0, outstanding}, 64'd1);

        // RAW on r5 stalls, writeback in cycle N releases in N+1
        clear_stim(); iv = 1;
        sv[SLOT_IXU2] = 1; r2[SLOT_IXU2] = 5; u2[SLOT_IXU2] = 1;
        cycle();
        cycle();
        chk("raw_stall_count", {48'd0, stall_cycles}, 64'd2);
        we[SLOT_IXU1] = 1; wr[SLOT_IXU1] = 5;
        cycle();
        chk("raw_ready_N", {63'd0, last_ready}, 64'd0);
        chk("raw_busy5_clr", {63'd0, busy[5]}, 64'd0);
        we[SLOT_IXU1] = 0;
        cycle();
        chk("raw_ready_N1", {63'd0, last_ready}, 64'd1);

        // WAW on r7, then an r0-only bundle
        clear_stim(); iv = 1;
        sv[0] = 1; rd[0] = 7; ud[0] = 1;
        cycle();
        clear_stim(); iv = 1;
        sv[SLOT_BRANCH] = 1; rd[SLOT_BRANCH] = 7; ud[SLOT_BRANCH] = 1;
        cycle();
        chk("waw_ready", {63'd0, last_ready}, 64'd0);
        clear_stim(); iv = 1;
        sv[0] = 1; rd[0] = 0; ud[0] = 1; r1[0] = 0; u1[0] = 1;
        cycle();
        chk("r0_ready", {63'd0, last_ready}, 64'd1);
        chk("r0_busy", {32'd0, busy}, 64'h80);
        clear_stim(); we[0] = 1; wr[0] = 7;
        cycle();

        // four writebacks while a new bundle issues r10
        clear_stim(); iv = 1;
        for (int s = 0; s < 4; s++) begin sv[s] = 1; rd[s] = s + 1; ud[s] = 1; end
        cycle();
        chk("four_busy", {32'd0, busy}, 64'h1E);
        clear_stim(); iv = 1;
        sv[0] = 1; rd[0] = 10; ud[0] = 1;
        for (int s = 0; s < 4; s++) begin we[s] = 1; wr[s] = s + 1; end
        cycle();
        chk("wb4_busy", {32'd0, busy}, 64'h400);
        chk("wb4_outstanding", {58'd0, outstanding}, 64'd1);

        // spurious writeback
        clear_stim(); we[2] = 1; wr[2] = 12;
        cycle();
        chk("spurious_set", {63'd0, spurious_wb_err}, 64'd1);

        // same rd on an invalid slot is not a duplicate
        clear_stim(); iv = 1;
        sv[0] = 1; rd[0] = 9; ud[0] = 1;
        sv[2] = 0; rd[2] = 9; ud[2] = 1;
        cycle();
        chk("nop_dup_ready", {63'd0, last_ready}, 64'd1);
        chk("nop_dup_err", {63'd0, dup_rd_err}, 64'd0);
        clear_stim(); we[0] = 1; wr[0] = 9; we[1] = 1; wr[1] = 10;
        cycle();

        // randomized phase, duplicates suppressed so the pipe keeps moving
        for (int n = 0; n < 400; n++) begin
            clear_stim();
            iv = ($urandom_range(0, 3) != 0) ? 1 : 0;
            for (int s = 0; s < 4; s++) begin
                sv[s] = $urandom_range(0, 1);
                r1[s] = $urandom_range(0, 15); u1[s] = $urandom_range(0, 1);
                r2[s] = $urandom_range(0, 15); u2[s] = $urandom_range(0, 1);
                rd[s] = $urandom_range(0, 15); ud[s] = $urandom_range(0, 1);
                for (int t = 0; t < s; t++)
                    if (dst_eff(s) && dst_eff(t) && rd[s] == rd[t]) ud[s] = 0;
                we[s] = ($urandom_range(0, 2) == 0) ? 1 : 0;
                wr[s] = $urandom_range(0, 15);
                if ($urandom_range(0, 3) != 0) begin
                    for (int k = 0; k < 16; k++) begin
                        int r = $urandom_range(1, 15);
                        if (mb[r]) begin wr[s] = r; break; end
                    end
                end
            end
            cycle();
        end

        // drain everything still busy
        for (int n = 0; n < 20 && mcount() != 0; n++) begin
            int q[$];
            clear_stim();
            for (int r = 1; r < 32; r++) if (mb[r]) q.push_back(r);
            for (int s = 0; s < 4 && s < q.size(); s++) begin we[s] = 1; wr[s] = q[s]; end
            cycle();
        end
        chk("drain_outstanding", {58'd0, outstanding}, 64'd0);

        clear_stim(); iv = 1; sv[1] = 1; rd[1] = 20; ud[1] = 1;
        cycle();

        // duplicate rd: sticky error, indefinite stall
        clear_stim(); iv = 1;
        sv[0] = 1; rd[0] = 9; ud[0] = 1;
        sv[2] = 1; rd[2] = 9; ud[2] = 1;
        cycle();
        chk("dup_ready", {63'd0, last_ready}, 64'd0);
        chk("dup_err", {63'd0, dup_rd_err}, 64'd1);

        // hold the stall long enough to saturate the counter
        repeat (70000) begin
            @(posedge clk);
            if (mstall < 65535) mstall++;
        end
        #1;
        chk("stall_saturated", {48'd0, stall_cycles}, 64'hFFFF);
        chk("dup_err_sticky", {63'd0, dup_rd_err}, 64'd1);
        chk("busy20_before_rst", {63'd0, busy[20]}, 64'd1);

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {32'd0, busy}, 64'd0);
        chk("arst_outstanding", {58'd0, outstanding}, 64'd0);
        chk("arst_errs", {62'd0, dup_rd_err, spurious_wb_err}, 64'd0);
        chk("arst_stall", {48'd0, stall_cycles}, 64'd0);
        model_reset();
        clear_stim();
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // writeback of a pre-reset destination is now spurious
        clear_stim(); we[1] = 1; wr[1] = 20;
        cycle();
        chk("post_rst_spurious", {63'd0, spurious_wb_err}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_scoreboard
`default_nettype wire

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Issue-stage hazard controller for the 4-slot VLIW register file (slot 0 LSU, slot 1 IXU1, slot 2 IXU2, slot 3 BRANCH). It tracks one busy bit per architectural register with a write in flight. It holds off a bundle until none of its sources or destinations collide with an in-flight write, and clears busy bits on each unit's register-file writeback. It also flags illegal bundles and spurious writebacks, and counts stall cycles.

Parameters:
NUM_SLOTS, 4, issue slots per bundle (one per functional unit)
NUM_REGS, 32, architectural registers; register 0 is hardwired zero
STALL_CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
issue_valid  in  1  decode presents a bundle
issue_ready  out  1  bundle accepted this cycle when high together with issue_valid
slot_valid  in  NUM_SLOTS  slot holds a real op (0 = NOP, ignored entirely)
slot_rs1  in  NUM_SLOTS x 5  source 1 index per slot
slot_rs1_use  in  NUM_SLOTS  slot reads rs1
slot_rs2  in  NUM_SLOTS x 5  source 2 index per slot
slot_rs2_use  in  NUM_SLOTS  slot reads rs2
slot_rd  in  NUM_SLOTS x 5  destination index per slot
slot_rd_use  in  NUM_SLOTS  slot writes rd
wb_en  in  NUM_SLOTS  unit writes back this cycle (same signal as the register-file write enable)
wb_rd  in  NUM_SLOTS x 5  writeback destination per unit
busy  out  NUM_REGS  registered busy vector; bit 0 always 0
outstanding  out  6  popcount of busy
dup_rd_err  out  1  sticky: bundle had two slots targeting the same nonzero rd
spurious_wb_err  out  1  sticky: writeback to a register that was not busy
stall_cycles  out  STALL_CNT_W  saturating count of cycles with issue_valid=1 and issue_ready=0

Behaviour:
- Reset (asynchronous): busy=0, outstanding=0, both error flags=0, stall_cycles=0. issue_ready follows the combinational rule below, so it is 1 out of reset for any bundle free of duplicate rd.
- Effective source: slot_valid & rsN_use & rsN!=0. Effective destination: slot_valid & rd_use & rd!=0. Register 0 never causes a hazard and is never set busy.
- RAW hazard: any effective source has busy[rs]=1.
- WAW hazard: any effective destination has busy[rd]=1.
- Dup-rd: two or more effective destinations share the same index.
- issue_ready = !(RAW | WAW | dup-rd). It is purely combinational from the registered busy vector and the slot inputs.
- No same-cycle bypass: a writeback in cycle N clears busy at edge N, so a dependent bundle can first be accepted in cycle N+1.
- Fire = issue_valid & issue_ready. On fire, busy[rd] is set at the edge for every effective destination. An intra-bundle RAW on a register that is not busy is legal (all slots read old values) and does not stall.
- Writeback: for each s with wb_en[s] & wb_rd[s]!=0, busy[wb_rd[s]] is cleared at the edge. A writeback while busy[idx]=0 sets spurious_wb_err; the bit stays 0.
- Set and clear of the same index in one cycle: set wins. Only reachable with a spurious writeback, which also raises spurious_wb_err.
- Multiple writebacks to the same index in one cycle: cleared once, no error if it was busy.
- dup_rd_err sets on any cycle with issue_valid & dup-rd. The bundle stalls indefinitely; recovery is by reset only.
- dup_rd_err and spurious_wb_err are cleared only by rst.
- stall_cycles increments on issue_valid & !issue_ready and holds at all-ones.
- outstanding is registered, updated in the same edge as busy, and reflects the next-state busy vector.
- issue_valid low: no state changes except writeback clears.
- Reset asserted mid-operation: busy state is dropped immediately. Any writebacks arriving after reset release are treated as spurious.

Decomposition:
- vliw_pkg: SLOT_LSU=0, SLOT_IXU1=1, SLOT_IXU2=2, SLOT_BRANCH=3, NUM_SLOTS, NUM_REGS, reg_idx_t (logic [4:0]), slot_vec_t.
- One sub-module, scoreboard_hazard_chk: combinational RAW/WAW/dup-rd detection from busy and slot fields.
- The top level holds the busy register, error flags and counters.

Test Plan:
- Reset, then bundle with slot1 rd=5 and slot0 rs1=3 -> issue_ready=1; after the edge busy[5]=1, outstanding=1.
- busy[5]=1, bundle slot2 rs2=5 -> issue_ready=0 and stall_cycles increments each cycle. wb_en[1]=1, wb_rd[1]=5 in cycle N -> busy[5]=0 after edge N, issue_ready=1 in N+1 (not N).
- busy[7]=1, bundle slot3 rd=7 (WAW) -> issue_ready=0. Bundle with rd=0 and rs1=0 only -> issue_ready=1 and busy unchanged.
- Bundle with slot0 rd=9 and slot2 rd=9 -> issue_ready=0, dup_rd_err=1 sticky; the same rd on a slot with slot_valid=0 -> no error.
- Four units write back distinct busy registers 1, 2, 3, 4 in one cycle while a bundle issues rd=10 -> busy={10}, outstanding=1. wb to non-busy reg 12 -> spurious_wb_err=1.
- Hold a hazard for 70000 cycles with STALL_CNT_W=16 -> stall_cycles=16'hFFFF. Assert rst mid-run -> all outputs 0 asynchronously, before the next clock edge.
